// File: rtl/usb_rx_ctrl_if.sv
// Signal bundle between the USB receive datapath (edge detector, bit timer,
// shift register, RX FIFO) and the receive control FSM.
interface usb_rx_ctrl_if;
    logic       d_edge;
    logic       eop;
    logic       shift_enable;
    logic       byte_received;
    logic [7:0] rcv_data;
    logic       rcving;
    logic       w_enable;
    logic       r_error;
    logic [6:0] pkt_len;

    modport master (
        output d_edge, eop, shift_enable, byte_received, rcv_data,
        input  rcving, w_enable, r_error, pkt_len
    );

    modport slave (
        input  d_edge, eop, shift_enable, byte_received, rcv_data,
        output rcving, w_enable, r_error, pkt_len
    );
endinterface

// File: rtl/usb_rx_ctrl.sv
// USB receive control FSM: sync detection, per-byte FIFO write strobes,
// packet length capture and sticky error handling until the bus idles again.
module usb_rx_ctrl #(
    parameter logic [7:0] SYNC_BYTE = 8'h80,
    parameter int         MAX_BYTES = 64
) (
    input logic          clk,
    input logic          n_rst,
    usb_rx_ctrl_if.slave bus
);
    localparam logic [2:0] IDLE       = 3'd0;
    localparam logic [2:0] SYNC_WAIT  = 3'd1;
    localparam logic [2:0] SYNC_CHECK = 3'd2;
    localparam logic [2:0] RX_BYTE    = 3'd3;
    localparam logic [2:0] STORE      = 3'd4;
    localparam logic [2:0] EOP_WAIT   = 3'd5;
    localparam logic [2:0] ERR_WAIT   = 3'd6;
    localparam logic [2:0] EIDLE      = 3'd7;

    localparam logic [6:0] MAX_CNT = 7'(MAX_BYTES);
    localparam logic [6:0] CNT_SAT = 7'h7f;

    logic [2:0] state;
    logic [2:0] state_nxt;
    logic [2:0] bit_cnt;
    logic [6:0] byte_cnt;
    logic [6:0] pkt_len_r;
    logic       err_eop;
    logic       eop_evt;
    logic       at_limit;

    assign eop_evt  = bus.eop & bus.shift_enable;
    // byte_cnt+1 == MAX_BYTES+1 means this byte would overflow the packet
    assign at_limit = (byte_cnt == MAX_CNT);

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:       if (bus.d_edge) state_nxt = SYNC_WAIT;
            SYNC_WAIT: begin
                if (eop_evt)                state_nxt = ERR_WAIT;
                else if (bus.byte_received) state_nxt = SYNC_CHECK;
            end
            SYNC_CHECK: state_nxt = (bus.rcv_data == SYNC_BYTE) ? RX_BYTE : ERR_WAIT;
            RX_BYTE: begin
                if (eop_evt)                state_nxt = (bit_cnt == 3'd0) ? EOP_WAIT : ERR_WAIT;
                else if (bus.byte_received) state_nxt = STORE;
            end
            STORE:      state_nxt = at_limit ? ERR_WAIT : RX_BYTE;
            EOP_WAIT:   if (bus.d_edge) state_nxt = IDLE;
            // only a d_edge after the SE0 has been seen ends the error packet
            ERR_WAIT:   if (err_eop && bus.d_edge) state_nxt = EIDLE;
            EIDLE:      if (bus.d_edge) state_nxt = SYNC_WAIT;
            default:    state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) state <= IDLE;
        else        state <= state_nxt;
    end

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst)
            bit_cnt <= 3'd0;
        else if (bus.byte_received || (state_nxt == RX_BYTE && state != RX_BYTE))
            bit_cnt <= 3'd0;
        else if (state == RX_BYTE && bus.shift_enable)
            bit_cnt <= bit_cnt + 3'd1;
    end

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst)
            byte_cnt <= 7'd0;
        else if ((state == IDLE || state == EIDLE) && bus.d_edge)
            byte_cnt <= 7'd0;
        else if (state == STORE && byte_cnt != CNT_SAT)
            byte_cnt <= byte_cnt + 7'd1;
    end

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst)                   err_eop <= 1'b0;
        else if (state != ERR_WAIT)   err_eop <= 1'b0;
        else if (eop_evt)             err_eop <= 1'b1;
    end

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst)                          pkt_len_r <= 7'd0;
        else if (state == EOP_WAIT && bus.d_edge) pkt_len_r <= byte_cnt;
    end

    assign bus.rcving   = (state != IDLE) && (state != EIDLE);
    assign bus.w_enable = (state == STORE) && !at_limit;
    assign bus.r_error  = (state == ERR_WAIT) || (state == EIDLE);
    assign bus.pkt_len  = pkt_len_r;
endmodule

// File: tb/tb_usb_rx_ctrl.sv
// Directed per-cycle vector bench for usb_rx_ctrl; a second instance with
// MAX_BYTES=2 covers packet overflow.
module tb_usb_rx_ctrl;
    typedef struct {
        logic       de, eo, se, br;
        logic [7:0] data;
        logic       rc, we, er;
        logic [6:0] len;
    } vec_t;

    logic clk;
    logic n_rst;
    int   total;
    int   passed;
    int   sel;

    usb_rx_ctrl_if ifa ();
    usb_rx_ctrl_if ifb ();

    assign ifb.d_edge        = ifa.d_edge;
    assign ifb.eop           = ifa.eop;
    assign ifb.shift_enable  = ifa.shift_enable;
    assign ifb.byte_received = ifa.byte_received;
    assign ifb.rcv_data      = ifa.rcv_data;

    usb_rx_ctrl dut (.clk(clk), .n_rst(n_rst), .bus(ifa));
    usb_rx_ctrl #(.SYNC_BYTE(8'h80), .MAX_BYTES(2)) dut2 (.clk(clk), .n_rst(n_rst), .bus(ifb));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic vec_t v(logic de, logic eo, logic se, logic br, logic [7:0] data,
                               logic rc, logic we, logic er, logic [6:0] len);
        vec_t r;
        r.de = de; r.eo = eo; r.se = se; r.br = br; r.data = data;
        r.rc = rc; r.we = we; r.er = er; r.len = len;
        return r;
    endfunction

    task automatic chk(input string name, input logic rc, input logic we,
                       input logic er, input logic [6:0] len);
        logic       a_rc, a_we, a_er;
        logic [6:0] a_len;
        if (sel == 0) begin
            a_rc = ifa.rcving; a_we = ifa.w_enable; a_er = ifa.r_error; a_len = ifa.pkt_len;
        end else begin
            a_rc = ifb.rcving; a_we = ifb.w_enable; a_er = ifb.r_error; a_len = ifb.pkt_len;
        end
        total++;
        if (a_rc === rc && a_we === we && a_er === er && a_len === len)
            passed++;
        else
            $display("FAIL %s: got rcving=%b w_enable=%b r_error=%b pkt_len=%0d, want %b %b %b %0d",
                     name, a_rc, a_we, a_er, a_len, rc, we, er, len);
    endtask

    task automatic run_tbl(input string name, input vec_t tbl[$]);
        foreach (tbl[i]) begin
            @(negedge clk);
            ifa.d_edge        = tbl[i].de;
            ifa.eop           = tbl[i].eo;
            ifa.shift_enable  = tbl[i].se;
            ifa.byte_received = tbl[i].br;
            ifa.rcv_data      = tbl[i].data;
            @(posedge clk);
            #1;
            chk($sformatf("%s[%0d]", name, i), tbl[i].rc, tbl[i].we, tbl[i].er, tbl[i].len);
        end
        @(negedge clk);
        ifa.d_edge = 0; ifa.eop = 0; ifa.shift_enable = 0; ifa.byte_received = 0;
    endtask

    task automatic do_reset();
        @(negedge clk);
        n_rst = 1'b0;
        @(negedge clk);
        n_rst = 1'b1;
    endtask

    vec_t ta[$];
    vec_t tm[$];
    vec_t tc[$];
    vec_t td[$];

    initial begin
        total = 0; passed = 0; sel = 0;
        ifa.d_edge = 0; ifa.eop = 0; ifa.shift_enable = 0; ifa.byte_received = 0;
        ifa.rcv_data = 8'h00;

        // good packet, bad sync, short byte, br+eop collision, eop in sync wait
        ta = '{
            v(1,0,0,0,8'h00, 1,0,0,0), v(0,0,0,0,8'h00, 1,0,0,0), v(0,0,1,0,8'h00, 1,0,0,0),
            v(0,0,0,1,8'h80, 1,0,0,0), v(0,0,0,0,8'h80, 1,0,0,0), v(0,0,1,0,8'h80, 1,0,0,0),
            v(0,0,0,1,8'hA5, 1,1,0,0), v(0,0,0,0,8'hA5, 1,0,0,0), v(0,0,0,1,8'h3C, 1,1,0,0),
            v(0,0,0,0,8'h3C, 1,0,0,0), v(0,0,0,1,8'h5A, 1,1,0,0), v(0,0,0,0,8'h5A, 1,0,0,0),
            v(0,1,1,0,8'h00, 1,0,0,0), v(0,1,0,0,8'h00, 1,0,0,0), v(1,0,0,0,8'h00, 0,0,0,3),
            v(0,0,0,0,8'h00, 0,0,0,3),
            v(1,0,0,0,8'h00, 1,0,0,3), v(0,0,0,1,8'h81, 1,0,0,3), v(0,0,0,0,8'h81, 1,0,1,3),
            v(1,0,0,0,8'h00, 1,0,1,3), v(0,1,1,0,8'h00, 1,0,1,3), v(0,0,0,0,8'h00, 1,0,1,3),
            v(1,0,0,0,8'h00, 0,0,1,3), v(0,0,0,0,8'h00, 0,0,1,3), v(1,0,0,0,8'h00, 1,0,0,3),
            v(0,0,0,1,8'h80, 1,0,0,3), v(0,0,0,0,8'h80, 1,0,0,3), v(0,0,0,1,8'h11, 1,1,0,3),
            v(0,0,0,0,8'h00, 1,0,0,3), v(0,0,1,0,8'h00, 1,0,0,3), v(0,0,1,0,8'h00, 1,0,0,3),
            v(0,0,1,0,8'h00, 1,0,0,3), v(0,0,1,0,8'h00, 1,0,0,3), v(0,1,1,0,8'h00, 1,0,1,3),
            v(0,1,1,0,8'h00, 1,0,1,3), v(1,0,0,0,8'h00, 0,0,1,3), v(1,0,0,0,8'h00, 1,0,0,3),
            v(0,0,0,1,8'h80, 1,0,0,3), v(0,0,0,0,8'h80, 1,0,0,3), v(0,1,1,1,8'h22, 1,0,0,3),
            v(0,0,0,0,8'h00, 1,0,0,3), v(1,0,0,0,8'h00, 0,0,0,0),
            v(1,0,0,0,8'h00, 1,0,0,0), v(0,1,1,1,8'h80, 1,0,1,0), v(0,1,1,0,8'h00, 1,0,1,0),
            v(1,0,0,0,8'h00, 0,0,1,0), v(1,0,0,0,8'h00, 1,0,0,0)
        };
        // MAX_BYTES=2 instance: third byte suppressed
        tm = '{
            v(1,0,0,0,8'h00, 1,0,0,0), v(0,0,0,1,8'h80, 1,0,0,0), v(0,0,0,0,8'h80, 1,0,0,0),
            v(0,0,0,1,8'h01, 1,1,0,0), v(0,0,0,0,8'h01, 1,0,0,0), v(0,0,0,1,8'h02, 1,1,0,0),
            v(0,0,0,0,8'h02, 1,0,0,0), v(0,0,0,1,8'h03, 1,0,0,0), v(0,0,0,0,8'h03, 1,0,1,0),
            v(0,1,1,0,8'h00, 1,0,1,0), v(1,0,0,0,8'h00, 0,0,1,0)
        };
        // into the second data byte, then reset
        tc = '{
            v(1,0,0,0,8'h00, 1,0,0,0), v(0,0,0,1,8'h80, 1,0,0,0), v(0,0,0,0,8'h80, 1,0,0,0),
            v(0,0,0,1,8'h44, 1,1,0,0), v(0,0,0,0,8'h00, 1,0,0,0), v(0,0,1,0,8'h00, 1,0,0,0),
            v(0,0,1,0,8'h00, 1,0,0,0)
        };
        // after reset release: no d_edge means nothing happens
        td = '{
            v(0,0,0,1,8'h80, 0,0,0,0), v(0,0,1,0,8'h80, 0,0,0,0), v(0,0,0,1,8'h55, 0,0,0,0),
            v(0,1,1,0,8'h00, 0,0,0,0), v(0,0,0,0,8'h00, 0,0,0,0), v(1,0,0,0,8'h00, 1,0,0,0)
        };

        n_rst = 1'b0;
        #12;
        chk("reset_state", 1'b0, 1'b0, 1'b0, 7'd0);
        @(negedge clk);
        n_rst = 1'b1;

        run_tbl("main", ta);

        do_reset();
        sel = 1;
        chk("reset2_state", 1'b0, 1'b0, 1'b0, 7'd0);
        run_tbl("max", tm);

        do_reset();
        sel = 0;
        run_tbl("pre_rst", tc);
        #2;
        n_rst = 1'b0;
        #1;
        chk("async_rst", 1'b0, 1'b0, 1'b0, 7'd0);
        @(negedge clk);
        ifa.byte_received = 1'b1;
        @(posedge clk);
        #1;
        chk("rst_held", 1'b0, 1'b0, 1'b0, 7'd0);
        @(negedge clk);
        ifa.byte_received = 1'b0;
        n_rst = 1'b1;
        run_tbl("post_rst", td);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
